// File: rtl/netlist_cell_evaluator.sv
// Sequential gate-netlist evaluator: loads a cell program, then runs one cell per clock over a net file.
// Optional NETLIST_EVAL_UNDRIVEN_CHECK_EN flags reads of nets that no cell or input has driven.
module netlist_cell_evaluator #(
    parameter int NET_AW  = 5,
    parameter int PROG_AW = 4,
    parameter int NUM_IN  = 4,
    parameter int NUM_OUT = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_prog_we,
    input  logic [PROG_AW-1:0]      i_prog_addr,
    input  logic [3+4*NET_AW-1:0]   i_prog_wdata,
    input  logic [PROG_AW:0]        i_prog_len,
    input  logic                    i_in_valid,
    output logic                    o_in_ready,
    input  logic [NUM_IN-1:0]       i_in_data,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic [NUM_OUT-1:0]      o_out_data,
    output logic                    o_busy,
    output logic                    o_err
);
    localparam int NET_COUNT  = 2**NET_AW;
    localparam int CW         = 3 + 4*NET_AW;
    localparam int PROG_DEPTH = 2**PROG_AW;
    localparam logic [PROG_AW:0] LEN_ONE = 1;

    typedef enum logic [1:0] {ST_IDLE, ST_EVAL, ST_DONE} state_t;

    state_t                 r_state, w_state_next;
    logic [CW-1:0]          r_prog [PROG_DEPTH];
    logic [PROG_AW-1:0]     r_pc;
    logic [PROG_AW:0]       r_len;
    logic [NET_COUNT-1:0]   r_nets;
    logic                   r_err;

    logic [CW-1:0]          w_cell;
    logic [2:0]             w_op;
    logic [NET_AW-1:0]      w_dst, w_a, w_b, w_s;
    logic                   w_na, w_nb, w_ns;
    logic                   w_val, w_wr, w_dst_in, w_accept, w_last, w_err_set;

    // Program memory is never reset; writes only land while idle.
    always_ff @(posedge i_clk) begin
        if (i_prog_we && r_state == ST_IDLE) begin
            r_prog[i_prog_addr] <= i_prog_wdata;
        end
    end

    assign w_cell   = r_prog[r_pc];
    assign w_op     = w_cell[CW-1 -: 3];
    assign w_dst    = w_cell[4*NET_AW-1 -: NET_AW];
    assign w_a      = w_cell[3*NET_AW-1 -: NET_AW];
    assign w_b      = w_cell[2*NET_AW-1 -: NET_AW];
    assign w_s      = w_cell[NET_AW-1:0];
    assign w_na     = r_nets[w_a];
    assign w_nb     = r_nets[w_b];
    assign w_ns     = r_nets[w_s];
    assign w_dst_in = (w_dst < NET_AW'(NUM_IN));
    assign w_accept = (r_state == ST_IDLE) && i_in_valid;
    assign w_last   = ({1'b0, r_pc} == (r_len - LEN_ONE));

    always_comb begin
        w_val = 1'b0;
        w_wr  = 1'b1;
        unique case (w_op)
            3'd0:    w_wr  = 1'b0;
            3'd1:    w_val = 1'b1;
            3'd2:    w_val = 1'b0;
            3'd3:    w_val = w_na & w_nb;
            3'd4:    w_val = w_na | w_nb;
            3'd5:    w_val = w_ns ? w_na : w_nb;
            3'd6:    w_val = ~w_na;
            default: w_val = w_na ^ w_nb;
        endcase
    end

`ifdef NETLIST_EVAL_UNDRIVEN_CHECK_EN
    logic [NET_COUNT-1:0] r_drv;
    logic                 w_src_undrv, w_out_undrv;

    // Only the source fields an opcode actually uses are checked.
    always_comb begin
        w_src_undrv = 1'b0;
        unique case (w_op)
            3'd3, 3'd4, 3'd7: w_src_undrv = !r_drv[w_a] || !r_drv[w_b];
            3'd5:             w_src_undrv = !r_drv[w_a] || !r_drv[w_b] || !r_drv[w_s];
            3'd6:             w_src_undrv = !r_drv[w_a];
            default:          w_src_undrv = 1'b0;
        endcase
    end

    assign w_out_undrv = ~&r_drv[NET_COUNT-1 -: NUM_OUT];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_drv <= '0;
        end else if (w_accept) begin
            r_drv <= NET_COUNT'({NUM_IN{1'b1}});
        end else if (r_state == ST_EVAL && w_wr && !w_dst_in) begin
            r_drv[w_dst] <= 1'b1;
        end
    end
`endif

    always_comb begin
        w_err_set = 1'b0;
        if (r_state == ST_EVAL) begin
            if (w_wr && w_dst_in) begin
                w_err_set = 1'b1;
            end
`ifdef NETLIST_EVAL_UNDRIVEN_CHECK_EN
            if (w_src_undrv) begin
                w_err_set = 1'b1;
            end
`endif
        end
`ifdef NETLIST_EVAL_UNDRIVEN_CHECK_EN
        if (r_state == ST_DONE && w_out_undrv) begin
            w_err_set = 1'b1;
        end
`endif
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: if (w_accept) w_state_next = (i_prog_len == '0) ? ST_DONE : ST_EVAL;
            ST_EVAL: if (w_last) w_state_next = ST_DONE;
            ST_DONE: if (i_out_ready) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
            r_len   <= '0;
            r_nets  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_nets <= NET_COUNT'(i_in_data);
                r_pc   <= '0;
                r_len  <= i_prog_len;
                r_err  <= 1'b0;
            end else begin
                r_err <= r_err | w_err_set;
                if (r_state == ST_EVAL) begin
                    r_pc <= r_pc + 1'b1;
                    // Input nets are read-only; the write is dropped and flagged.
                    if (w_wr && !w_dst_in) begin
                        r_nets[w_dst] <= w_val;
                    end
                end
            end
        end
    end

    assign o_in_ready  = (r_state == ST_IDLE);
    assign o_busy      = (r_state != ST_IDLE);
    assign o_out_valid = (r_state == ST_DONE);
    assign o_out_data  = r_nets[NET_COUNT-1 -: NUM_OUT];
`ifdef NETLIST_EVAL_UNDRIVEN_CHECK_EN
    assign o_err       = r_err | ((r_state == ST_DONE) && w_out_undrv);
`else
    assign o_err       = r_err;
`endif

endmodule

// File: tb/tb_netlist_cell_evaluator.sv
// Bench for netlist_cell_evaluator: directed scenarios plus random programs checked against a
// sequential interpreter of the cell program.
module tb_netlist_cell_evaluator;
    logic        clk;
    logic        rst_n;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [22:0] prog_wdata;
    logic [4:0]  prog_len;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_data;
    logic        busy;
    logic        err;

    int total = 0;
    int bad   = 0;
    int txn   = 0;

    logic [2:0] sh_op  [16];
    logic [4:0] sh_dst [16];
    logic [4:0] sh_a   [16];
    logic [4:0] sh_b   [16];
    logic [4:0] sh_s   [16];

    netlist_cell_evaluator dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_prog_we    (prog_we),
        .i_prog_addr  (prog_addr),
        .i_prog_wdata (prog_wdata),
        .i_prog_len   (prog_len),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_in_data    (in_data),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_out_data   (out_data),
        .o_busy       (busy),
        .o_err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // Straight interpretation of the program: nets as a bit array, cells applied in order.
    function automatic void model(input logic [3:0] din, input int len,
                                  output logic [1:0] od, output logic oe);
        bit nets [32];
        bit drv  [32];
        bit v;
        bit rd;
        oe = 1'b0;
        for (int i = 0; i < 32; i++) begin
            nets[i] = (i < 4) ? din[i] : 1'b0;
            drv[i]  = (i < 4);
        end
        for (int c = 0; c < len; c++) begin
            int op, d, a, b, s;
            op = int'(sh_op[c]); d = int'(sh_dst[c]);
            a = int'(sh_a[c]); b = int'(sh_b[c]); s = int'(sh_s[c]);
            rd = 1'b1;
            case (op)
                1: v = 1'b1;
                2: v = 1'b0;
                3: begin v = nets[a] & nets[b]; rd = drv[a] && drv[b]; end
                4: begin v = nets[a] | nets[b]; rd = drv[a] && drv[b]; end
                5: begin v = nets[s] ? nets[a] : nets[b]; rd = drv[a] && drv[b] && drv[s]; end
                6: begin v = !nets[a]; rd = drv[a]; end
                7: begin v = nets[a] ^ nets[b]; rd = drv[a] && drv[b]; end
                default: v = 1'b0;
            endcase
`ifdef NETLIST_EVAL_UNDRIVEN_CHECK_EN
            if (!rd) oe = 1'b1;
`endif
            if (op != 0) begin
                if (d < 4) begin
                    oe = 1'b1;
                end else begin
                    nets[d] = v;
                    drv[d]  = 1'b1;
                end
            end
        end
`ifdef NETLIST_EVAL_UNDRIVEN_CHECK_EN
        if (!drv[30] || !drv[31]) oe = 1'b1;
`endif
        od = {nets[31], nets[30]};
    endfunction

    task automatic load_cell(input int addr, input logic [2:0] op, input logic [4:0] d,
                             input logic [4:0] a, input logic [4:0] b, input logic [4:0] s);
        @(negedge clk);
        prog_we    = 1'b1;
        prog_addr  = 4'(addr);
        prog_wdata = {op, d, a, b, s};
        @(posedge clk);
        #1;
        prog_we = 1'b0;
        sh_op[addr] = op; sh_dst[addr] = d; sh_a[addr] = a; sh_b[addr] = b; sh_s[addr] = s;
    endtask

    task automatic run(input logic [3:0] din, input int len, input int hold, input bit corrupt,
                       output logic [1:0] od, output logic oe);
        logic [1:0] exp_d;
        logic       exp_e;
        int         cycles;
        model(din, len, exp_d, exp_e);
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = din;
        prog_len = 5'(len);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 4'($urandom);
        prog_len = 5'($urandom);
        if (len > 0) check("err_clr_on_accept", 32'(err), 32'd0);
        if (corrupt) begin
            prog_we    = 1'b1;
            prog_addr  = 4'($urandom_range(0, 15));
            prog_wdata = 23'($urandom);
        end
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!out_valid && cycles < 64);
        prog_we = 1'b0;
        check("latency", 32'(cycles), 32'(len + 1));
        check("out_data", 32'(out_data), 32'(exp_d));
        check("err", 32'(err), 32'(exp_e));
        check("in_ready_busy", 32'(in_ready), 32'd0);
        check("busy", 32'(busy), 32'd1);
        od = out_data;
        oe = err;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'(out_data), 32'(exp_d));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("post_valid", 32'(out_valid), 32'd0);
        check("post_in_ready", 32'(in_ready), 32'd1);
        txn++;
        $display("txn %0d: in=%b len=%0d cycles=%0d out=%b err=%b exp_out=%b exp_err=%b",
                 txn, din, len, cycles, od, oe, exp_d, exp_e);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_data"}, 32'(out_data), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        logic [1:0] od;
        logic       oe;
        logic       exp_undrv_err;

        rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0; prog_len = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("after_reset");

        // Mux of gates: n31 = n0 ? (n1&n2) : (n1|n2)
        load_cell(0, 3'd3, 5'd4, 5'd1, 5'd2, 5'd0);
        load_cell(1, 3'd4, 5'd5, 5'd1, 5'd2, 5'd0);
        load_cell(2, 3'd5, 5'd31, 5'd4, 5'd5, 5'd0);
        run(4'b0011, 3, 0, 1'b0, od, oe);
        check("mux_ctrl1", 32'(od[1]), 32'd0);
        run(4'b0010, 3, 0, 1'b0, od, oe);
        check("mux_ctrl0", 32'(od[1]), 32'd1);

        // Program writes while busy must be dropped; the rerun still sees the mux program.
        run(4'b0010, 3, 0, 1'b1, od, oe);
        run(4'b0010, 3, 0, 1'b0, od, oe);
        check("rerun_after_we", 32'(od), 32'd2);

        // Constants
        load_cell(0, 3'd1, 5'd30, 5'd0, 5'd0, 5'd0);
        load_cell(1, 3'd2, 5'd31, 5'd0, 5'd0, 5'd0);
        run(4'b1111, 2, 1, 1'b0, od, oe);
        check("const_data", 32'(od), 32'd1);
        check("const_err", 32'(oe), 32'd0);

        // Zero-length run held in DONE
        run(4'b1010, 0, 5, 1'b0, od, oe);
        check("len0_data", 32'(od), 32'd0);

        // Write to an input net: suppressed, flagged, net1 keeps its value
        load_cell(0, 3'd6, 5'd1, 5'd2, 5'd0, 5'd0);
        load_cell(1, 3'd4, 5'd31, 5'd1, 5'd1, 5'd0);
        run(4'b0110, 2, 0, 1'b0, od, oe);
        check("innet_err", 32'(oe), 32'd1);
        check("innet_kept", 32'(od[1]), 32'd1);
        run(4'b0110, 2, 0, 1'b0, od, oe);

        // Undriven source n9
        load_cell(0, 3'd3, 5'd31, 5'd1, 5'd9, 5'd0);
`ifdef NETLIST_EVAL_UNDRIVEN_CHECK_EN
        exp_undrv_err = 1'b1;
`else
        exp_undrv_err = 1'b0;
`endif
        run(4'b0010, 1, 0, 1'b0, od, oe);
        check("undrv_data", 32'(od[1]), 32'd0);
        check("undrv_err", 32'(oe), 32'(exp_undrv_err));

        // Reset in the middle of EVAL after n31 has been set and err raised
        load_cell(0, 3'd1, 5'd31, 5'd0, 5'd0, 5'd0);
        load_cell(1, 3'd6, 5'd0, 5'd0, 5'd0, 5'd0);
        load_cell(2, 3'd0, 5'd0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 4'b0101;
        prog_len = 5'd16;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_eval_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("mid_reset_release");

        // Random programs
        for (int it = 0; it < 24; it++) begin
            int len;
            for (int c = 0; c < 16; c++) begin
                int r;
                logic [4:0] d;
                r = int'($urandom_range(0, 5));
                d = (r < 2) ? 5'(30 + r) : 5'($urandom_range(1, 9));
                load_cell(c, 3'($urandom_range(0, 7)), d,
                          5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)),
                          5'($urandom_range(0, 9)));
            end
            len = int'($urandom_range(0, 16));
            run(4'($urandom), len, int'($urandom_range(0, 2)), 1'($urandom), od, oe);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/netlist_cell_evaluator.md
Name: netlist_cell_evaluator

Overview:
- Sequential engine that reads and executes a gate-level cell netlist of the kind our synthesis flow writes (VCC, GND, AND2, OR2, MUX2, NOT, XOR2 cells over numbered nets).
- A host loads a cell program, then streams input vectors in. The engine evaluates one cell per clock and returns the output nets over a valid/ready handshake.
- Used as an on-chip checker for synthesized combinational logic: the engine consumes a netlist where the synthesizer produces one.

Parameters:
- NET_AW, 5, net index width; NET_COUNT = 2**NET_AW nets.
- PROG_AW, 4, program address width; program depth is 2**PROG_AW cells.
- NUM_IN, 4, primary inputs, mapped to nets 0..NUM_IN-1.
- NUM_OUT, 2, primary outputs. out_data[i] = net[NET_COUNT-NUM_OUT+i].

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- prog_we  in  1  program write strobe. Ignored while busy=1.
- prog_addr  in  PROG_AW  program write address.
- prog_wdata  in  3+4*NET_AW  cell word, fields MSB to LSB: {op[2:0], dst, a, b, s}.
- prog_len  in  PROG_AW+1  number of cells to execute, 0..2**PROG_AW. Sampled on input accept.
- in_valid  in  1  input vector valid.
- in_ready  out  1  high in IDLE only.
- in_data  in  NUM_IN  input vector; bit i drives net i.
- out_valid  out  1  result valid.
- out_ready  in  1  result accepted.
- out_data  out  NUM_OUT  output net values.
- busy  out  1  high in any state except IDLE.
- err  out  1  sticky error flag. Cleared on the next input accept.

Behaviour:
- Async reset forces: state IDLE, pc=0, all nets=0, in_ready=1, out_valid=0, out_data=0, busy=0, err=0. Program memory is not reset.
- Opcodes:
  - 0 NOP: no write.
  - 1 VCC: dst=1.
  - 2 GND: dst=0.
  - 3 AND2: dst=a&b.
  - 4 OR2: dst=a|b.
  - 5 MUX2: dst = net[s] ? net[a] : net[b].
  - 6 NOT: dst=~a.
  - 7 XOR2: dst=a^b.
  - Unused fields are don't-care.
- IDLE: in_ready=1. On in_valid&&in_ready (cycle T):
  - net[0..NUM_IN-1] load in_data; all other nets clear to 0.
  - pc=0, err=0, len latched from prog_len.
  - Next state is EVAL, or DONE if len==0.
- EVAL: executes cell[pc] combinationally from the current net values and writes dst at the clock edge.
  - Each cell sees the results of all earlier cells, so cells execute in program order.
  - pc increments each cycle. After executing pc==len-1, next state is DONE.
- DONE: out_valid=1; out_data is driven from the output nets and held stable until out_ready. On out_valid&&out_ready, next state is IDLE with in_ready=1 on the following cycle.
- Latency: accept at T, EVAL during T+1..T+len, out_valid at T+len+1. For len=0, out_valid is at T+1 and out_data reflects no cell execution.
- Write to an input net (dst<NUM_IN): the write is suppressed and err is set; execution continues.
- dst equal to a source of the same cell: the old value is read, then the net is overwritten.
- prog_we while busy: the write is dropped and the program is unchanged. prog_we in IDLE takes effect for the next accept.
- in_valid while busy: not accepted, because in_ready=0.
- Reset asserted mid-EVAL or in DONE: immediate return to reset values. Any pending result is lost.

Optional Feature:
- Macro: NETLIST_EVAL_UNDRIVEN_CHECK_EN.
- Defined:
  - Keep a per-net driven bit. Input nets are set on accept; all other nets are cleared.
  - A cell write sets the driven bit of its dst.
  - Reading an undriven source sets err. Only fields used by the opcode are checked: a for NOT; a,b for 2-input cells; a,b,s for MUX2.
  - In DONE, any undriven output net also sets err.
  - Undriven nets still evaluate as 0.
- Not defined: no driven tracking; undriven nets read 0 silently; err comes only from writes to input nets.

Test Plan:
- Mux-of-gates program:
  - Inputs: net0=ctrl, net1=in1, net2=in2. Cells: AND2 n4=n1&n2; OR2 n5=n1|n2; MUX2 n31 = n0 ? n4 : n5; len=3.
  - Apply in_data={ctrl=1,in1=1,in2=0} -> out_valid at T+4, out_data[1]=0.
  - Apply ctrl=0 with the same in1/in2 -> out_data[1]=1.
- Constants: len=2, cells VCC n30 and GND n31 -> out_data=2'b01 at T+3, err=0.
- len=0 -> out_valid at T+1, out_data=0. Hold out_ready=0 for 5 cycles -> out_valid and out_data stay stable, in_ready=0.
- Input-net write: cell NOT dst=1 a=2 -> err=1 at DONE, net1 keeps its input value. The next accept clears err.
- Protocol robustness:
  - prog_we during EVAL -> program unchanged, verified by rerun.
  - rst_n low mid-EVAL -> out_valid=0 and in_ready=1 immediately after rst_n deasserts.
- With NETLIST_EVAL_UNDRIVEN_CHECK_EN: AND2 n4=n1&n9 where n9 was never written -> err=1, n4=0. Without the macro, the same program gives err=0, n4=0.
